zmips_mem_arb: RTL

ZMIPS_MEM_ARB -- requirements
Module: zmips_mem_arb

---
 rtl/zmips_pkg.sv | 17 +
 rtl/zmips_mem_arb.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/zmips_pkg.sv
// Shared constants and types for the ZMIPS memory arbiter.
package zmips_pkg;

    localparam int ZMIPS_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/zmips_mem_arb.sv
// Single-port memory arbiter between instruction fetch and data access,
// with a streak limit so a waiting fetch cannot be starved by data traffic.
module zmips_mem_arb
    import zmips_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int STREAK_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ZMIPS_XLEN-1:0] if_addr,
    output logic                  if_ack,
    output logic [ZMIPS_XLEN-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ZMIPS_XLEN-1:0] d_addr,
    input  logic [ZMIPS_XLEN-1:0] d_wdata,
    output logic                  d_ack,
    output logic [ZMIPS_XLEN-1:0] d_rdata,
    output logic [ZMIPS_XLEN-1:0] mem_addr,
    output logic [ZMIPS_XLEN-1:0] mem_wdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    input  logic [ZMIPS_XLEN-1:0] mem_rdata
);

    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int SW = (STREAK_MAX > 0) ? $clog2(STREAK_MAX + 1) : 1;
    localparam logic [CW-1:0] WAIT_LOAD  = CW'(WAIT_STATES);
    localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);

    arb_state_e            state_q, state_d;
    arb_owner_e            owner_q, owner_d;
    logic                  we_q, we_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         streak_q, streak_d;
    logic [ZMIPS_XLEN-1:0] addr_q, addr_d;
    logic [ZMIPS_XLEN-1:0] wdata_q, wdata_d;
    logic [ZMIPS_XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [ZMIPS_XLEN-1:0] d_rdata_q, d_rdata_d;
    logic                  fetch_win_s;

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_FETCH;
            we_q       <= 1'b0;
            cnt_q      <= {CW{1'b0}};
            streak_q   <= {SW{1'b0}};
            addr_q     <= {ZMIPS_XLEN{1'b0}};
            wdata_q    <= {ZMIPS_XLEN{1'b0}};
            if_rdata_q <= {ZMIPS_XLEN{1'b0}};
            d_rdata_q  <= {ZMIPS_XLEN{1'b0}};
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign fetch_win_s = if_req && (!d_req || (streak_q == STREAK_LIM));

    // Next-state logic: arbitration in IDLE, wait countdown in ACCESS.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (fetch_win_s) begin
                    state_d  = ACCESS;
                    owner_d  = OWN_FETCH;
                    we_d     = 1'b0;
                    addr_d   = if_addr;
                    wdata_d  = {ZMIPS_XLEN{1'b0}};
                    cnt_d    = WAIT_LOAD;
                    streak_d = {SW{1'b0}};
                end else if (d_req) begin
                    state_d = ACCESS;
                    owner_d = OWN_DATA;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    cnt_d   = WAIT_LOAD;
                    // Only data grants that bypass a waiting fetch count toward the streak.
                    if (if_req && (streak_q != STREAK_LIM)) begin
                        streak_d = streak_q + SW'(1);
                    end else begin
                        streak_d = streak_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q != {CW{1'b0}}) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = ACK;
                    if (!we_q) begin
                        if (owner_q == OWN_FETCH) begin
                            if_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_rd    = (state_q == ACCESS) && !we_q;
    assign mem_wr    = (state_q == ACCESS) && we_q;
    assign if_ack    = (state_q == ACK) && (owner_q == OWN_FETCH);
    assign d_ack     = (state_q == ACK) && (owner_q == OWN_DATA);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
